// File: rtl/glitch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : glitch_pkg
// Purpose  : Shared opcodes, bus/ack encodings, instruction fields and states
// Revision : 1.0
// ============================================================================
package glitch_pkg;

  localparam logic [1:0] OP_I2C_CHK = 2'b00;
  localparam logic [1:0] OP_DAC_UP  = 2'b01;
  localparam logic [1:0] OP_DELAY   = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  localparam logic PRIV_BUS = 1'b1;
  localparam logic MAIN_BUS = 1'b0;
  localparam logic ACK      = 1'b0;
  localparam logic NAK      = 1'b1;

  localparam int INSTR_W = 12;
  localparam int OPC_HI  = 11;
  localparam int OPC_LO  = 10;
  localparam int BUS_BIT = 9;
  localparam int DATA_HI = 8;
  localparam int DATA_LO = 1;
  localparam int ACK_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_I2C = 3'd2,
    ST_WAIT_DLY = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERR      = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/glitch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : glitch_sequencer_if
// Purpose  : Control, ROM, sniffed-I2C, DAC and status signals of the sequencer
// Revision : 1.0
// ============================================================================
interface glitch_sequencer_if;
  logic        start;
  logic        abort;
  logic [7:0]  instr_pt;
  logic [11:0] instr;
  logic [7:0]  delay_num;
  logic [31:0] delay_len;
  logic        i2c_valid;
  logic        i2c_bus;
  logic [7:0]  i2c_byte;
  logic        i2c_ack;
  logic [7:0]  dac_code;
  logic        dac_load;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, abort, instr, delay_len, i2c_valid, i2c_bus, i2c_byte, i2c_ack,
    input  instr_pt, delay_num, dac_code, dac_load, busy, done, err
  );

  modport slave (
    input  start, abort, instr, delay_len, i2c_valid, i2c_bus, i2c_byte, i2c_ack,
    output instr_pt, delay_num, dac_code, dac_load, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/glitch_delay_timer.sv
`default_nettype none
// ============================================================================
// Module   : glitch_delay_timer
// Purpose  : 32-bit loadable down-counter with terminal-count (count == 1) flag
// Revision : 1.0
// ============================================================================
module glitch_delay_timer (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_load,
  input  wire logic        i_en,
  input  wire logic [31:0] i_load_val,
  output logic             o_tc
);

  logic [31:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 32'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != 32'd0)) begin
      r_count <= r_count - 32'd1;
    end
  end

  assign o_tc = (r_count == 32'd1);

endmodule
`default_nettype wire

// File: rtl/glitch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : glitch_sequencer
// Purpose  : Fetches/executes ROM instructions (I2C match, DAC load, delay).
//            GLITCH_SEQ_LOOP_EN: program end wraps to instruction 0 instead of DONE.
// Revision : 1.0
// ============================================================================
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int PROG_LEN = 14
) (
  input  wire logic          clk,
  input  wire logic          rst,
  glitch_sequencer_if.slave  seq_if
);

  localparam logic [7:0] c_prog_end = 8'(PROG_LEN);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_instr_pt, w_instr_pt_nxt;
  logic [7:0]  r_dac_code, w_dac_code_nxt;
  logic        r_dac_load, w_dac_load_nxt;
  logic        r_busy, r_done, r_err;
  logic        r_bus, w_bus_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic        r_ack, w_ack_nxt;
  logic [7:0]  r_delay_num;
  logic [7:0]  w_delay_num;
  logic        w_tmr_load, w_tmr_en, w_tmr_tc;

  logic [1:0]  w_opcode;
  logic        w_ibus;
  logic [7:0]  w_idata;
  logic        w_iack;

  assign w_opcode = seq_if.instr[OPC_HI:OPC_LO];
  assign w_ibus   = seq_if.instr[BUS_BIT];
  assign w_idata  = seq_if.instr[DATA_HI:DATA_LO];
  assign w_iack   = seq_if.instr[ACK_BIT];

  // ROM delay index follows the instruction while fetching, then holds.
  assign w_delay_num = (r_state == ST_FETCH) ? w_idata : r_delay_num;

  glitch_delay_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_en       (w_tmr_en),
    .i_load_val (seq_if.delay_len),
    .o_tc       (w_tmr_tc)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_instr_pt_nxt = r_instr_pt;
    w_dac_code_nxt = r_dac_code;
    w_dac_load_nxt = 1'b0;
    w_bus_nxt      = r_bus;
    w_data_nxt     = r_data;
    w_ack_nxt      = r_ack;
    w_tmr_load     = 1'b0;
    w_tmr_en       = 1'b0;

    if (seq_if.abort) begin
      w_state_nxt    = ST_IDLE;
      w_instr_pt_nxt = 8'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (seq_if.start) begin
            w_state_nxt    = ST_FETCH;
            w_instr_pt_nxt = 8'd0;
          end
        end
        ST_FETCH: begin
          if (r_instr_pt == c_prog_end) begin
`ifdef GLITCH_SEQ_LOOP_EN
            w_instr_pt_nxt = 8'd0;
`else
            w_state_nxt    = ST_DONE;
`endif
          end else begin
            case (w_opcode)
              OP_I2C_CHK: begin
                w_state_nxt = ST_WAIT_I2C;
                w_bus_nxt   = w_ibus;
                w_data_nxt  = w_idata;
                w_ack_nxt   = w_iack;
              end
              OP_DAC_UP: begin
                w_dac_code_nxt = w_idata;
                w_dac_load_nxt = 1'b1;
                w_instr_pt_nxt = r_instr_pt + 8'd1;
              end
              OP_DELAY: begin
                w_tmr_load = 1'b1;
                if (seq_if.delay_len == 32'd0) begin
                  w_instr_pt_nxt = r_instr_pt + 8'd1;
                end else begin
                  w_state_nxt = ST_WAIT_DLY;
                end
              end
              default: w_state_nxt = ST_ERR;
            endcase
          end
        end
        ST_WAIT_I2C: begin
          if (seq_if.i2c_valid && (seq_if.i2c_bus == r_bus)) begin
            w_state_nxt = ST_FETCH;
            // A mismatch restarts the trigger pattern; the offending byte is dropped.
            if ((seq_if.i2c_byte == r_data) && (seq_if.i2c_ack == r_ack)) begin
              w_instr_pt_nxt = r_instr_pt + 8'd1;
            end else begin
              w_instr_pt_nxt = 8'd0;
            end
          end
        end
        ST_WAIT_DLY: begin
          w_tmr_en = 1'b1;
          if (w_tmr_tc) begin
            w_state_nxt    = ST_FETCH;
            w_instr_pt_nxt = r_instr_pt + 8'd1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_instr_pt  <= 8'd0;
      r_dac_code  <= 8'd0;
      r_dac_load  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_bus       <= 1'b0;
      r_data      <= 8'd0;
      r_ack       <= 1'b0;
      r_delay_num <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_instr_pt  <= w_instr_pt_nxt;
      r_dac_code  <= w_dac_code_nxt;
      r_dac_load  <= w_dac_load_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE) &&
                     (w_state_nxt != ST_ERR);
      r_done      <= (w_state_nxt == ST_DONE);
      r_err       <= (w_state_nxt == ST_ERR);
      r_bus       <= w_bus_nxt;
      r_data      <= w_data_nxt;
      r_ack       <= w_ack_nxt;
      r_delay_num <= w_delay_num;
    end
  end

  assign seq_if.instr_pt  = r_instr_pt;
  assign seq_if.delay_num = w_delay_num;
  assign seq_if.dac_code  = r_dac_code;
  assign seq_if.dac_load  = r_dac_load;
  assign seq_if.busy      = r_busy;
  assign seq_if.done      = r_done;
  assign seq_if.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_glitch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_glitch_sequencer
// Purpose  : Scoreboard bench: directed programs, DAC/DONE/ERR events checked by cycle
// Revision : 1.0
// ============================================================================
module tb_glitch_sequencer;

  localparam int K_DAC  = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_pass;
  int   n_total;
  bit   mon_en;
  logic prev_done;
  logic prev_err;
  exp_t exp_q[$];

  logic [11:0] prog [0:3];
  logic [31:0] dly  [0:3];

  glitch_sequencer_if sif ();

  glitch_sequencer #(.PROG_LEN(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_if (sif)
  );

  assign sif.instr     = (sif.instr_pt < 8'd4) ? prog[sif.instr_pt[1:0]] : 12'h000;
  assign sif.delay_len = (sif.delay_num < 8'd4) ? dly[sif.delay_num[1:0]] : 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int kind, input int val, input int c);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input int val);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: got kind %0d value %0h at cycle %0d, expected none",
               kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_value", val, e.val);
      check("event_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sif.dac_load) got(K_DAC, int'(sif.dac_code));
      if (sif.done && !prev_done) got(K_DONE, 0);
      if (sif.err && !prev_err) got(K_ERR, 0);
    end
    prev_done = sif.done;
    prev_err  = sif.err;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(output int fc);
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    fc = cyc;
  endtask

  task automatic pulse_abort();
    sif.abort = 1'b1;
    @(negedge clk);
    sif.abort = 1'b0;
  endtask

  task automatic strobe(input logic bus, input logic [7:0] b, input logic ack, output int e);
    sif.i2c_valid = 1'b1;
    sif.i2c_bus   = bus;
    sif.i2c_byte  = b;
    sif.i2c_ack   = ack;
    @(negedge clk);
    sif.i2c_valid = 1'b0;
    e = cyc;
  endtask

  initial begin
    int fc;
    int e;
    n_pass = 0;  n_total = 0;  cyc = 0;  mon_en = 1'b0;
    sif.start = 1'b0;  sif.abort = 1'b0;
    sif.i2c_valid = 1'b0;  sif.i2c_bus = 1'b0;  sif.i2c_byte = 8'h00;  sif.i2c_ack = 1'b0;
    prog[0] = 12'h802;  prog[1] = 12'h802;  prog[2] = 12'h802;  prog[3] = 12'h802;
    dly[0] = 32'd0;  dly[1] = 32'd0;  dly[2] = 32'd8000;  dly[3] = 32'd20;

    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_instr_pt", sif.instr_pt, 0);
    check("rst_delay_num", sif.delay_num, 0);
    check("rst_dac_code", sif.dac_code, 0);
    check("rst_dac_load", sif.dac_load, 0);
    check("rst_busy", sif.busy, 0);
    check("rst_done", sif.done, 0);
    check("rst_err", sif.err, 0);
    mon_en = 1'b1;
    tick(2);

    // Trigger on 0x84/priv/ACK, then DAC 0xED
    prog[0] = 12'h308;  prog[1] = 12'h5DA;  prog[2] = 12'h802;  prog[3] = 12'h802;
    pulse_start(fc);
    check("t1_busy", sif.busy, 1);
    tick(2);
    strobe(1'b1, 8'h84, 1'b0, e);
    push(K_DAC, 'hED, e + 1);
`ifndef GLITCH_SEQ_LOOP_EN
    push(K_DONE, 0, e + 4);
`endif
    tick(4);
`ifdef GLITCH_SEQ_LOOP_EN
    check("t1_wrap_instr_pt", sif.instr_pt, 0);
    check("t1_wrap_done", sif.done, 0);
    check("t1_wrap_busy", sif.busy, 1);
`else
    check("t1_done", sif.done, 1);
    check("t1_done_busy", sif.busy, 0);
`endif
    tick(2);
    pulse_abort();
    check("t1_abort_busy", sif.busy, 0);
    tick(2);

    // Pattern 0x84,0x01 on priv with wrong-bus and mismatch bytes
    prog[0] = 12'h308;  prog[1] = 12'h202;  prog[2] = 12'h478;  prog[3] = 12'h802;
    pulse_start(fc);
    tick(2);
    strobe(1'b1, 8'h84, 1'b0, e);
    check("t2_first_match", sif.instr_pt, 1);
    tick(2);
    strobe(1'b0, 8'h01, 1'b0, e);
    tick(2);
    check("t2_main_ignored", sif.instr_pt, 1);
    strobe(1'b1, 8'h02, 1'b0, e);
    check("t2_mismatch_restart", sif.instr_pt, 0);
    tick(2);
    strobe(1'b1, 8'h84, 1'b0, e);
    tick(2);
    strobe(1'b1, 8'h01, 1'b0, e);
    push(K_DAC, 'h3C, e + 1);
`ifndef GLITCH_SEQ_LOOP_EN
    push(K_DONE, 0, e + 3);
`endif
    tick(5);
    pulse_abort();
    tick(2);

    // Long delay of 8000 ticks ahead of DAC 0x5A
    prog[0] = 12'h804;  prog[1] = 12'h4B4;  prog[2] = 12'h802;  prog[3] = 12'h802;
    pulse_start(fc);
    check("t3_delay_num_fetch", sif.delay_num, 2);
    push(K_DAC, 'h5A, fc + 8002);
`ifndef GLITCH_SEQ_LOOP_EN
    push(K_DONE, 0, fc + 8005);
`endif
    tick(5);
    check("t3_busy_wait", sif.busy, 1);
    check("t3_delay_num_hold", sif.delay_num, 2);
    tick(8002);
    pulse_abort();
    tick(2);

    // Abort mid-delay, then abort together with start
    prog[0] = 12'h806;  prog[1] = 12'h4EE;  prog[2] = 12'h802;  prog[3] = 12'h802;
    pulse_start(fc);
    tick(5);
    pulse_abort();
    check("t4_abort_busy", sif.busy, 0);
    check("t4_abort_dac_load", sif.dac_load, 0);
    check("t4_abort_instr_pt", sif.instr_pt, 0);
    tick(40);
    pulse_start(fc);
    tick(5);
    sif.abort = 1'b1;
    sif.start = 1'b1;
    @(negedge clk);
    sif.abort = 1'b0;
    sif.start = 1'b0;
    check("t4_abort_start_busy", sif.busy, 0);
    tick(40);

    // Abort in the fetch cycle of a DAC_UP suppresses the load
    prog[0] = 12'h4EE;
    pulse_start(fc);
    pulse_abort();
    check("t4_dac_abort_load", sif.dac_load, 0);
    check("t4_dac_abort_code", sif.dac_code, 'h5A);
    check("t4_dac_abort_busy", sif.busy, 0);
    tick(5);

    // Reserved opcode at instruction 3
    prog[0] = 12'h802;  prog[1] = 12'h802;  prog[2] = 12'h802;  prog[3] = 12'hC00;
    pulse_start(fc);
    push(K_ERR, 0, fc + 4);
    tick(4);
    check("t5_err", sif.err, 1);
    check("t5_err_busy", sif.busy, 0);
    tick(2);
    pulse_start(fc);
    check("t5_restart_err", sif.err, 0);
    check("t5_restart_instr_pt", sif.instr_pt, 0);
    check("t5_restart_busy", sif.busy, 1);
    push(K_ERR, 0, fc + 4);
    tick(6);
    pulse_abort();
    tick(5);

    while (exp_q.size() != 0) begin
      exp_t pend;
      pend = exp_q.pop_front();
      n_total++;
      $display("FAIL missing_event: got nothing, expected kind %0d value %0h at cycle %0d",
               pend.kind, pend.val, pend.cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
